// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer.
// Class encodings, FSM states and per-class hold lengths.
package instr_sequencer_pkg;

  localparam logic [1:0] CLS_HALT  = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam int STD_CYCLES   = 3;
  localparam int LOAD_CYCLES  = 4;
  localparam int STORE_CYCLES = 3;

  localparam int CNT_BITS = 3;
  localparam logic [CNT_BITS-1:0] CNT_ONE = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_PRIME,
    S_ISSUE,
    S_HALT
  } state_t;

  function automatic logic [CNT_BITS-1:0] hold_cycles(
    input logic [1:0] cls
  );
    logic [CNT_BITS-1:0] n;
    n = '0;
    case (cls)
      CLS_STD:   n = CNT_BITS'(STD_CYCLES);
      CLS_LOAD:  n = CNT_BITS'(LOAD_CYCLES);
      CLS_STORE: n = CNT_BITS'(STORE_CYCLES);
      default:   n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/instr_sequencer_prefetch_buf.sv
// One-entry prefetch buffer with fetch pointer and
// the single-outstanding req/ack handshake.
module instr_prefetch_buf #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   launch,
  input  logic                   consume,
  input  logic                   flush,
  output logic                   imem_req,
  output logic [PC_BITS-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ack,
  output logic                   hit,
  output logic [INSTR_WIDTH-1:0] word
);

  localparam logic [PC_BITS-1:0] PC_ONE = PC_BITS'(1);

  logic [INSTR_WIDTH-1:0] buf_q;
  logic                   buf_v;
  logic [PC_BITS-1:0]     fptr;
  logic                   ack_ok;

  // an ack only counts against a live request
  assign ack_ok = imem_ack & imem_req;
  assign hit    = buf_v | ack_ok;
  assign word   = buf_v ? buf_q : imem_rdata;

  // handshake, fetch pointer and buffer capture
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req  <= 1'b0;
      imem_addr <= '0;
      fptr      <= '0;
      buf_q     <= '0;
      buf_v     <= 1'b0;
    end else if (flush) begin
      imem_req <= 1'b0;
      buf_v    <= 1'b0;
    end else begin
      if (launch) begin
        imem_req  <= 1'b1;
        imem_addr <= fptr;
        fptr      <= fptr + PC_ONE;
      end else if (ack_ok) begin
        imem_req <= 1'b0;
      end
      if (consume) begin
        buf_v <= 1'b0;
      end else if (ack_ok) begin
        buf_v <= 1'b1;
        buf_q <= imem_rdata;
      end
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer: holds each instruction for
// its class length and prefetches one word ahead.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5,
  parameter int RET_BITS    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic                   imem_req,
  output logic [PC_BITS-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ack,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   halted,
  output logic                   underrun,
  output logic [RET_BITS-1:0]    retired
);

  localparam logic [PC_BITS-1:0]  PC_ONE  = PC_BITS'(1);
  localparam logic [RET_BITS-1:0] RET_ONE = RET_BITS'(1);

  state_t                 state;
  logic [CNT_BITS-1:0]    cnt;
  logic                   hit;
  logic [INSTR_WIDTH-1:0] word;
  logic [1:0]             word_cls;
  logic [1:0]             instr_cls;
  logic                   boundary;
  logic                   go;
  logic                   launch;
  logic                   consume;
  logic                   flush;
  logic [RET_BITS-1:0]    ret_inc;

  assign word_cls  = word[INSTR_WIDTH-1 -: 2];
  assign instr_cls = instr[INSTR_WIDTH-1 -: 2];
  assign boundary  = (state == S_ISSUE) && (cnt == CNT_ONE);
  assign go        = boundary && run && hit
                     && (word_cls != CLS_HALT);
  assign launch    = ((state == S_IDLE) && run)
                     || (state == S_PRIME) || go;
  assign consume   = ((state == S_FETCH0) && hit)
                     || (boundary && run && hit);
  assign flush     = ((state == S_FETCH0) && hit
                      && (word_cls == CLS_HALT))
                     || (boundary && !go);
  assign ret_inc   = (&retired) ? retired
                                : retired + RET_ONE;

  instr_prefetch_buf #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .PC_BITS     (PC_BITS)
  ) u_pfb (
    .clk        (clk),
    .rst        (rst),
    .launch     (launch),
    .consume    (consume),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .hit        (hit),
    .word       (word)
  );

  // sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      instr    <= '0;
      pc       <= '0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      underrun <= 1'b0;
      retired  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (run) state <= S_FETCH0;
        end
        S_FETCH0: begin
          if (hit) begin
            if (word_cls == CLS_HALT) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              instr <= word;
              pc    <= '0;
              busy  <= 1'b1;
              state <= S_PRIME;
            end
          end
        end
        S_PRIME: begin
          cnt   <= hold_cycles(instr_cls);
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!boundary) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            retired <= ret_inc;
            if (go) begin
              instr <= word;
              pc    <= pc + PC_ONE;
              cnt   <= hold_cycles(word_cls);
            end else begin
              state    <= S_HALT;
              instr    <= '0;
              busy     <= 1'b0;
              halted   <= 1'b1;
              underrun <= run & ~hit;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
